cpu_ctrl: RTL and testbench

Instruction register, decoder and control FSM that sits directly upstream of the 8x16 register file and its datapath. It drives the register file's readnum, writenum and write signals, and the datapath's load, select and ALU controls, for a 16-bit ISA subset: MOV imm, MOV reg, ADD, CMP, AND and MVN. It accounts for the register file's registered read: data_out is valid one cycle after readnum is presented with write=0. It also accounts for the fact that no read occurs in a cycle with write=1.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/instr_dec.sv | 30 +++
 rtl/cpu_ctrl.sv | 112 +++++++++++
 tb/tb_cpu_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and encodings for the instruction decoder and control FSM.
package cpu_pkg;

   typedef enum logic [2:0] {
      S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_LOAD_B, S_EXEC, S_WB, S_WR_IMM
   } state_e;

   typedef enum logic [2:0] {
      C_UNDEF, C_MOV_IMM, C_MOV_REG, C_ADD, C_CMP, C_AND, C_MVN
   } iclass_e;

   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;

   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_ADD     = 2'b00;
   localparam logic [1:0] OP_CMP     = 2'b01;
   localparam logic [1:0] OP_AND     = 2'b10;
   localparam logic [1:0] OP_MVN     = 2'b11;

   localparam logic [1:0] VSEL_C    = 2'b00;
   localparam logic [1:0] VSEL_IMM8 = 2'b01;

   typedef struct packed {
      iclass_e     cls;
      logic [2:0]  rn;
      logic [2:0]  rd;
      logic [2:0]  rm;
      logic [1:0]  sh;
      logic [1:0]  op;
      logic [15:0] sximm8;
      logic [15:0] sximm5;
   } dec_t;

endpackage

// File: rtl/instr_dec.sv
// instr_dec: field extraction, sign extension and instruction-class decode of the IR.
module instr_dec
   import cpu_pkg::*;
(
   input  logic [15:0] ir,
   output dec_t        dec
);

   logic [2:0] opc;
   logic [1:0] op;

   assign opc = ir[15:13];
   assign op  = ir[12:11];

   always_comb begin
      dec.rn     = ir[10:8];
      dec.rd     = ir[7:5];
      dec.sh     = ir[4:3];
      dec.rm     = ir[2:0];
      dec.op     = op;
      dec.sximm8 = {{8{ir[7]}}, ir[7:0]};
      dec.sximm5 = {{11{ir[4]}}, ir[4:0]};
      dec.cls    = (opc == OPC_ALU) ? ((op == OP_ADD) ? C_ADD :
                                       (op == OP_CMP) ? C_CMP :
                                       (op == OP_AND) ? C_AND : C_MVN) :
                   (opc == OPC_MOV && op == OP_MOV_IMM) ? C_MOV_IMM :
                   (opc == OPC_MOV && op == OP_MOV_REG) ? C_MOV_REG : C_UNDEF;
   end

endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: instruction register and Moore control FSM driving the register file and datapath.
module cpu_ctrl
   import cpu_pkg::*;
#(
   parameter int DW = 16,
   parameter int RW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          s,
   input  logic          load,
   input  logic [DW-1:0] in,
   output logic          w,
   output logic [RW-1:0] readnum,
   output logic [RW-1:0] writenum,
   output logic          write,
   output logic [1:0]    vsel,
   output logic          loada,
   output logic          loadb,
   output logic          loadc,
   output logic          loads,
   output logic          asel,
   output logic          bsel,
   output logic [1:0]    shift,
   output logic [1:0]    ALUop,
   output logic [DW-1:0] sximm8,
   output logic [DW-1:0] sximm5
);

   state_e        state_q, state_d;
   logic [DW-1:0] ir_q, ir_d;
   dec_t          dec;
   logic          uses_a;

   instr_dec u_dec (.ir(ir_q), .dec(dec));

   assign uses_a = dec.cls inside {C_ADD, C_CMP, C_AND};
   assign sximm8 = dec.sximm8;
   assign sximm5 = dec.sximm5;
   assign shift  = (dec.cls == C_MOV_IMM) ? 2'b00 : dec.sh;
   assign ALUop  = (dec.cls == C_MOV_REG) ? OP_ADD : dec.op;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_WAIT;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // Read index stays on Rm through LOAD_B because the register file output lags readnum by a cycle.
   always_comb begin
      ir_d     = (state_q == S_WAIT && load) ? in : ir_q;
      state_d  = state_q;
      w        = 1'b0;
      readnum  = '0;
      writenum = '0;
      write    = 1'b0;
      vsel     = VSEL_C;
      loada    = 1'b0;
      loadb    = 1'b0;
      loadc    = 1'b0;
      loads    = 1'b0;
      asel     = 1'b0;
      bsel     = 1'b0;
      case (state_q)
         S_WAIT: begin
            w       = 1'b1;
            state_d = s ? S_DECODE : S_WAIT;
         end
         S_DECODE: state_d = (dec.cls == C_MOV_IMM) ? S_WR_IMM :
                             uses_a ? S_GET_A :
                             (dec.cls inside {C_MOV_REG, C_MVN}) ? S_GET_B : S_WAIT;
         S_GET_A: begin
            readnum = dec.rn;
            state_d = S_GET_B;
         end
         S_GET_B: begin
            readnum = dec.rm;
            loada   = uses_a;
            state_d = S_LOAD_B;
         end
         S_LOAD_B: begin
            readnum = dec.rm;
            loadb   = 1'b1;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            asel    = dec.cls == C_MOV_REG;
            loads   = dec.cls == C_CMP;
            loadc   = dec.cls != C_CMP;
            state_d = (dec.cls == C_CMP) ? S_WAIT : S_WB;
         end
         S_WB: begin
            write    = 1'b1;
            writenum = dec.rd;
            vsel     = VSEL_C;
            state_d  = S_WAIT;
         end
         S_WR_IMM: begin
            write    = 1'b1;
            writenum = dec.rn;
            vsel     = VSEL_IMM8;
            state_d  = S_WAIT;
         end
         default: state_d = S_WAIT;
      endcase
   end

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: directed scoreboard bench; expected per-cycle outputs are queued at issue and checked each cycle.
module tb_cpu_ctrl;

   logic        clk = 1'b0;
   logic        reset, s, load;
   logic [15:0] in;
   logic        w, write, loada, loadb, loadc, loads, asel, bsel;
   logic [2:0]  readnum, writenum;
   logic [1:0]  vsel, shift, ALUop;
   logic [15:0] sximm8, sximm5;

   int          errors = 0;
   int          checks = 0;
   logic [15:0] ir_m;
   logic        noise = 1'b0;

   typedef struct {
      string       tag;
      logic [15:0] ctl;
      logic        chk_alu;
      logic [1:0]  alu;
      logic [1:0]  sh;
      logic [15:0] imm8;
      logic [15:0] imm5;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   cpu_ctrl dut (
      .clk(clk), .reset(reset), .s(s), .load(load), .in(in), .w(w),
      .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
      .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
      .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
      .sximm8(sximm8), .sximm5(sximm5)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // ctl layout: {w, readnum, writenum, write, vsel, loada, loadb, loadc, loads, asel, bsel}
   task automatic push(input string tag, input logic [15:0] ctl, input logic chk,
                       input logic [1:0] alu, input logic [1:0] sh);
      exp_t e;
      e.tag = tag; e.ctl = ctl; e.chk_alu = chk; e.alu = alu; e.sh = sh;
      e.imm8 = {{8{ir_m[7]}}, ir_m[7:0]};
      e.imm5 = {{11{ir_m[4]}}, ir_m[4:0]};
      sb.push_back(e);
   endtask

   task automatic e_wait();              push("wait",   {1'b1, 3'd0, 3'd0, 1'b0, 2'b00, 6'b000000}, 1'b0, 2'b00, 2'b00); endtask
   task automatic e_dec();               push("decode", {1'b0, 3'd0, 3'd0, 1'b0, 2'b00, 6'b000000}, 1'b0, 2'b00, 2'b00); endtask
   task automatic e_geta(input logic [2:0] rn); push("get_a", {1'b0, rn, 3'd0, 1'b0, 2'b00, 6'b000000}, 1'b0, 2'b00, 2'b00); endtask
   task automatic e_getb(input logic [2:0] rm, input logic la);
      push("get_b", {1'b0, rm, 3'd0, 1'b0, 2'b00, la, 5'b00000}, 1'b0, 2'b00, 2'b00);
   endtask
   task automatic e_loadb(input logic [2:0] rm); push("load_b", {1'b0, rm, 3'd0, 1'b0, 2'b00, 6'b010000}, 1'b0, 2'b00, 2'b00); endtask
   task automatic e_exec(input logic lc, input logic ls, input logic as, input logic [1:0] alu, input logic [1:0] sh);
      push("exec", {1'b0, 3'd0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, lc, ls, as, 1'b0}, 1'b1, alu, sh);
   endtask
   task automatic e_wb(input logic [2:0] rd);    push("wb",     {1'b0, 3'd0, rd, 1'b1, 2'b00, 6'b000000}, 1'b0, 2'b00, 2'b00); endtask
   task automatic e_wrimm(input logic [2:0] rn); push("wr_imm", {1'b0, 3'd0, rn, 1'b1, 2'b01, 6'b000000}, 1'b0, 2'b00, 2'b00); endtask

   task automatic check();
      exp_t        e;
      logic [15:0] obs;
      e   = sb.pop_front();
      obs = {w, readnum, writenum, write, vsel, loada, loadb, loadc, loads, asel, bsel};
      checks++;
      assert (obs === e.ctl) else begin errors++; $error("FAIL %s ctl observed=%h expected=%h", e.tag, obs, e.ctl); end
      checks++;
      assert (sximm8 === e.imm8) else begin errors++; $error("FAIL %s sximm8 observed=%h expected=%h", e.tag, sximm8, e.imm8); end
      checks++;
      assert (sximm5 === e.imm5) else begin errors++; $error("FAIL %s sximm5 observed=%h expected=%h", e.tag, sximm5, e.imm5); end
      if (e.chk_alu) begin
         checks++;
         assert (ALUop === e.alu) else begin errors++; $error("FAIL %s ALUop observed=%b expected=%b", e.tag, ALUop, e.alu); end
         checks++;
         assert (shift === e.sh) else begin errors++; $error("FAIL %s shift observed=%b expected=%b", e.tag, shift, e.sh); end
      end
   endtask

   task automatic run();
      while (sb.size() > 0) begin
         check();
         if (sb.size() > 0) begin
            if (noise) begin
               s = ~s; load = 1'b1; in = 16'hFFFF;
            end
            step();
         end
      end
   endtask

   task automatic issue(input logic [15:0] instr, input logic ld);
      in = instr; load = ld; s = 1'b1;
      if (ld) ir_m = instr;
      step();
      s = 1'b0; load = 1'b0;
   endtask

   initial begin
      reset = 1'b1; s = 1'b0; load = 1'b0; in = 16'h0; ir_m = 16'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      e_wait();
      run();

      // MOV R0,#7
      issue(16'hD007, 1'b1);
      e_dec(); e_wrimm(3'd0); e_wait();
      run();

      // MOV R1,#-2: load alone in WAIT, then start without load
      in = 16'hD1FE; load = 1'b1; ir_m = 16'hD1FE;
      step();
      load = 1'b0;
      e_wait();
      run();
      issue(16'h1234, 1'b0);
      e_dec(); e_wrimm(3'd1); e_wait();
      run();

      // ADD R2,R1,R0 LSL#1
      issue(16'hA148, 1'b1);
      e_dec(); e_geta(3'd1); e_getb(3'd0, 1'b1); e_loadb(3'd0);
      e_exec(1'b1, 1'b0, 1'b0, 2'b00, 2'b01); e_wb(3'd2); e_wait();
      run();

      // CMP R1,R0 with s/load/in toggling throughout execution
      issue(16'hA900, 1'b1);
      noise = 1'b1;
      e_dec(); e_geta(3'd1); e_getb(3'd0, 1'b1); e_loadb(3'd0);
      e_exec(1'b0, 1'b1, 1'b0, 2'b01, 2'b00); e_wait();
      run();
      noise = 1'b0; s = 1'b0; load = 1'b0;

      // undefined opcode
      issue(16'hE000, 1'b1);
      e_dec(); e_wait();
      run();

      // undefined 110/01
      issue(16'hC800, 1'b1);
      e_dec(); e_wait();
      run();

      // MOV R3,R1
      issue(16'hC061, 1'b1);
      e_dec(); e_getb(3'd1, 1'b0); e_loadb(3'd1);
      e_exec(1'b1, 1'b0, 1'b1, 2'b00, 2'b00); e_wb(3'd3); e_wait();
      run();

      // MVN R4,R2 LSR
      issue(16'hB892, 1'b1);
      e_dec(); e_getb(3'd2, 1'b0); e_loadb(3'd2);
      e_exec(1'b1, 1'b0, 1'b0, 2'b11, 2'b10); e_wb(3'd4); e_wait();
      run();

      // AND R5,R6,R7
      issue(16'hB6A7, 1'b1);
      e_dec(); e_geta(3'd6); e_getb(3'd7, 1'b1); e_loadb(3'd7);
      e_exec(1'b1, 1'b0, 1'b0, 2'b10, 2'b00); e_wb(3'd5); e_wait();
      run();

      // ADD aborted by reset during GET_B
      issue(16'hA148, 1'b1);
      e_dec(); e_geta(3'd1); e_getb(3'd0, 1'b1);
      run();
      reset = 1'b1;
      step();
      reset = 1'b0; ir_m = 16'h0;
      e_wait(); e_wait(); e_wait(); e_wait();
      run();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
